// File: rtl/updown_counter_n_pkg.sv
// Shared constants for the up/down counter: saturation modes and default width.
package updown_counter_n_pkg;

  localparam int unsigned SAT_WRAP      = 0;
  localparam int unsigned SAT_HOLD      = 1;
  localparam int unsigned DEFAULT_WIDTH = 4;

endpackage

// File: rtl/updown_counter_n_dffpc.sv
// Generic WIDTH-bit D register with asynchronous active-low clear.
module dffpc_n #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// Bounded up/down counter (range 0..lim) with load, clear, wrap/saturate modes,
// terminal-count pulse and sticky saturation flag.
module updown_counter_n
  import updown_counter_n_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned SAT   = SAT_WRAP
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             en,
  input  logic             X,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] lim,
  input  logic             sclr,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             sat_hit
);

  localparam bit HOLD = (SAT == SAT_HOLD);

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_tc_nxt;
  logic             w_sat_nxt;

  // Next-state: sclr > ld > en; idle holds Q and sat_hit with tc low.
  always_comb begin
    w_q_nxt   = Q;
    w_tc_nxt  = 1'b0;
    w_sat_nxt = sat_hit;
    if (sclr) begin
      w_q_nxt   = '0;
      w_sat_nxt = 1'b0;
    end else if (ld) begin
      w_q_nxt = (ld_val > lim) ? lim : ld_val;
    end else if (en) begin
      if (Q > lim) begin
        // Count stranded above a lowered limit: re-enter the range.
        if (X) begin
          w_q_nxt  = '0;
          w_tc_nxt = 1'b1;
        end else begin
          w_q_nxt = lim;
        end
      end else if (X) begin
        if (Q == lim) begin
          w_tc_nxt = 1'b1;
          if (HOLD) begin
            w_sat_nxt = 1'b1;
          end else begin
            w_q_nxt = '0;
          end
        end else begin
          w_q_nxt = Q + WIDTH'(1);
        end
      end else begin
        if (Q == '0) begin
          w_tc_nxt = 1'b1;
          if (HOLD) begin
            w_sat_nxt = 1'b1;
          end else begin
            w_q_nxt = lim;
          end
        end else begin
          w_q_nxt = Q - WIDTH'(1);
        end
      end
    end
  end

  dffpc_n #(.WIDTH(WIDTH)) u_q_reg (
    .clk   (clk),
    .clr_n (CLR),
    .d     (w_q_nxt),
    .q     (Q)
  );

  dffpc_n #(.WIDTH(1)) u_tc_reg (
    .clk   (clk),
    .clr_n (CLR),
    .d     (w_tc_nxt),
    .q     (tc)
  );

  dffpc_n #(.WIDTH(1)) u_sat_reg (
    .clk   (clk),
    .clr_n (CLR),
    .d     (w_sat_nxt),
    .q     (sat_hit)
  );

endmodule

// File: tb/tb_updown_counter_n.sv
// Self-checking bench: a wrap-mode and a hold-mode counter share stimulus and are
// compared against constant tables, hand sequences and a behavioural model.
module tb_updown_counter_n;

  localparam int unsigned W = 4;

  logic         clk;
  logic         clr_n;
  logic         en;
  logic         x;
  logic         ld;
  logic [W-1:0] ld_val;
  logic [W-1:0] lim;
  logic         sclr;
  logic [W-1:0] q_w;
  logic         tc_w;
  logic         sat_w;
  logic [W-1:0] q_h;
  logic         tc_h;
  logic         sat_h;

  int checks   = 0;
  int failures = 0;

  int mq   [2];
  bit msat [2];
  bit mtc  [2];

  updown_counter_n #(.WIDTH(W), .SAT(0)) u_wrap (
    .clk(clk), .CLR(clr_n), .en(en), .X(x), .ld(ld), .ld_val(ld_val),
    .lim(lim), .sclr(sclr), .Q(q_w), .tc(tc_w), .sat_hit(sat_w)
  );

  updown_counter_n #(.WIDTH(W), .SAT(1)) u_hold (
    .clk(clk), .CLR(clr_n), .en(en), .X(x), .ld(ld), .ld_val(ld_val),
    .lim(lim), .sclr(sclr), .Q(q_h), .tc(tc_h), .sat_hit(sat_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit en, x, ld, sclr;
    int ld_val, lim;
    int exp_q;
    bit exp_tc;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour for one clock edge, written from the counting rules.
  function automatic void model(input bit hold, inout int q, inout bit sat, output bit t);
    int top;
    top = int'(lim);
    t = 1'b0;
    if (sclr) begin
      q = 0; sat = 1'b0;
    end else if (ld) begin
      q = (int'(ld_val) < top) ? int'(ld_val) : top;
    end else if (en) begin
      if (q > top) begin
        if (x) begin q = 0; t = 1'b1; end
        else q = top;
      end else if (x && q == top) begin
        t = 1'b1;
        if (hold) sat = 1'b1; else q = 0;
      end else if (!x && q == 0) begin
        t = 1'b1;
        if (hold) sat = 1'b1; else q = top;
      end else begin
        q = x ? q + 1 : q - 1;
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; msat[i] = 1'b0; mtc[i] = 1'b0;
    end
  endtask

  task automatic cmp_model();
    chk("wrap_q",   int'(q_w),   mq[0]);
    chk("wrap_tc",  int'(tc_w),  int'(mtc[0]));
    chk("wrap_sat", int'(sat_w), int'(msat[0]));
    chk("hold_q",   int'(q_h),   mq[1]);
    chk("hold_tc",  int'(tc_h),  int'(mtc[1]));
    chk("hold_sat", int'(sat_h), int'(msat[1]));
  endtask

  task automatic step();
    model(1'b0, mq[0], msat[0], mtc[0]);
    model(1'b1, mq[1], msat[1], mtc[1]);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic drive(input bit e, input bit d, input bit l, input int lv,
                       input int lm, input bit sc);
    en = e; x = d; ld = l; ld_val = W'(lv); lim = W'(lm); sclr = sc;
  endtask

  // Asynchronous clear pulse between edges; outputs must drop before the next edge.
  task automatic pulse_clr();
    #2;
    clr_n = 1'b0;
    #1;
    model_reset();
    chk("clr_async_wrap_q", int'(q_w), 0);
    chk("clr_async_hold_q", int'(q_h), 0);
    chk("clr_async_tc",     int'(tc_w | tc_h), 0);
    chk("clr_async_sat",    int'(sat_w | sat_h), 0);
    #2;
    clr_n = 1'b1;
  endtask

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{1,1,0,0, 0,5, 1,0}, '{1,1,0,0, 0,5, 2,0}, '{1,1,0,0, 0,5, 3,0},
      '{1,1,0,0, 0,5, 4,0}, '{1,1,0,0, 0,5, 5,0}, '{1,1,0,0, 0,5, 0,1},
      '{1,1,0,0, 0,5, 1,0}, '{1,1,0,0, 0,5, 2,0},
      '{0,0,0,1, 0,5, 0,0},
      '{1,0,0,0, 0,5, 5,1}, '{1,0,0,0, 0,5, 4,0}, '{1,0,0,0, 0,5, 3,0},
      '{0,0,1,0,12,7, 7,0}, '{0,0,1,1,12,7, 0,0},
      '{0,0,1,0,10,15,10,0}, '{1,1,0,0, 0,6, 0,1},
      '{0,0,1,0,10,15,10,0}, '{1,0,0,0, 0,6, 6,0},
      '{0,1,0,0, 0,6, 6,0},
      '{1,1,0,0, 0,0, 0,1}, '{1,1,0,0, 0,0, 0,1}, '{1,0,0,0, 0,0, 0,1},
      '{0,0,1,0,15,15,15,0}, '{1,1,0,0, 0,15, 0,1}, '{1,0,0,0, 0,15,15,1},
      '{1,0,0,0, 0,15,14,0}, '{1,1,0,0, 0,15,15,0}
    };

    clr_n = 1'b0;
    drive(1, 1, 1, 9, 15, 0);
    model_reset();
    #12;
    chk("reset_wrap_q", int'(q_w), 0);
    chk("reset_hold_q", int'(q_h), 0);
    chk("reset_tc",     int'(tc_w | tc_h), 0);
    chk("reset_sat",    int'(sat_w | sat_h), 0);
    @(posedge clk);
    #1;
    chk("reset_ignores_inputs", int'(q_w), 0);
    drive(0, 0, 0, 0, 5, 0);
    clr_n = 1'b1;

    // Directed table against fixed wrap-mode expectations.
    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].x, vecs[i].ld, vecs[i].ld_val, vecs[i].lim, vecs[i].sclr);
      step();
      chk($sformatf("vec%0d_q", i),  int'(q_w),  vecs[i].exp_q);
      chk($sformatf("vec%0d_tc", i), int'(tc_w), int'(vecs[i].exp_tc));
    end

    // Saturating mode: load 8 under lim 9, then push up into the ceiling.
    drive(0, 0, 0, 0, 9, 1); step();
    drive(0, 0, 1, 8, 9, 0); step();
    chk("sat_load_q", int'(q_h), 8);
    drive(1, 1, 0, 0, 9, 0); step();
    chk("sat_c1_q", int'(q_h), 9); chk("sat_c1_tc", int'(tc_h), 0); chk("sat_c1_hit", int'(sat_h), 0);
    step();
    chk("sat_c2_q", int'(q_h), 9); chk("sat_c2_tc", int'(tc_h), 1); chk("sat_c2_hit", int'(sat_h), 1);
    step();
    chk("sat_c3_q", int'(q_h), 9); chk("sat_c3_tc", int'(tc_h), 1); chk("sat_c3_hit", int'(sat_h), 1);
    drive(0, 1, 0, 0, 9, 0); step();
    chk("sat_idle_tc", int'(tc_h), 0); chk("sat_sticky", int'(sat_h), 1);
    drive(0, 0, 0, 0, 9, 1); step();
    chk("sat_sclr_hit", int'(sat_h), 0); chk("sat_sclr_q", int'(q_h), 0);

    // Async clear mid-count at Q=4, then resume counting.
    drive(1, 1, 0, 0, 9, 0);
    for (int i = 0; i < 4; i++) step();
    chk("pre_clr_q", int'(q_w), 4);
    pulse_clr();
    step(); chk("resume1_q", int'(q_w), 1);
    step(); chk("resume2_q", int'(q_w), 2);

    // Randomised traffic against the model.
    for (int c = 0; c < 600; c++) begin
      en     = ($urandom_range(0, 3) != 0);
      x      = $urandom_range(0, 1) == 1;
      ld     = ($urandom_range(0, 15) == 0);
      ld_val = W'($urandom_range(0, 15));
      sclr   = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       lim = W'(0);
          1:       lim = W'(15);
          default: lim = W'($urandom_range(0, 15));
        endcase
      end
      if ((c % 97) == 50) pulse_clr();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 Parameter SAT, default 0: 0 = wrap at range ends, 1 = saturate (hold) at range ends.
REQ-003 clk  input  1: single clock; all state updates on its rising edge.
REQ-004 CLR  input  1: reset, asynchronous, active-low.
REQ-005 en  input  1: count enable; when 1, one step per clock.
REQ-006 X  input  1: direction; 1 = up, 0 = down.
REQ-007 ld  input  1: synchronous parallel load strobe.
REQ-008 ld_val  input  WIDTH: parallel load value.
REQ-009 lim  input  WIDTH: upper bound of the count range; the range is 0..lim inclusive.
REQ-010 sclr  input  1: synchronous clear.
REQ-011 Q  output  WIDTH: registered count value.
REQ-012 tc  output  1: registered terminal-count pulse.
REQ-013 sat_hit  output  1: registered sticky flag; set by a saturation event, cleared by sclr or reset.

Function
REQ-014 Per-cycle priority SHALL be sclr > ld > en; with none asserted, Q and sat_hit SHALL hold and tc SHALL be 0.
REQ-015 sclr=1 SHALL set Q=0, tc=0 and sat_hit=0 on the next edge.
REQ-016 ld=1 SHALL set Q=min(ld_val, lim) on the next edge, with tc=0.
REQ-017 en=1, X=1, Q<lim SHALL set Q=Q+1; en=1, X=0, Q>0 SHALL set Q=Q-1; tc=0 in both cases.
REQ-018 Up boundary (en=1, X=1, Q==lim): when SAT=0, Q SHALL become 0; when SAT=1, Q SHALL hold and sat_hit SHALL set. In both modes tc SHALL be 1 for exactly that cycle.
REQ-019 Down boundary (en=1, X=0, Q==0): when SAT=0, Q SHALL become lim; when SAT=1, Q SHALL hold and sat_hit SHALL set. In both modes tc SHALL be 1 for that cycle.
REQ-020 Q>lim (lim lowered mid-count), en=1: X=1 SHALL give Q=0 with tc=1; X=0 SHALL give Q=lim with tc=0.
REQ-021 lim=0 SHALL pin Q at 0: every enabled step is a boundary event and asserts tc.
REQ-022 X changing on any cycle SHALL take effect on that same edge; no turnaround cycle.
REQ-023 Arithmetic SHALL be unsigned WIDTH-bit with no intermediate overflow; lim=2^WIDTH-1 SHALL behave as a full-range counter.
REQ-024 Latency from any input to Q, tc or sat_hit SHALL be one clock edge; outputs SHALL have no combinational path from inputs.

Reset
REQ-025 CLR=0 SHALL force Q=0, tc=0 and sat_hit=0 immediately, independent of clk.
REQ-026 While CLR=0, all inputs SHALL be ignored.
REQ-027 The first count SHALL occur on the first rising clk edge after CLR deasserts, with normal priority.
REQ-028 CLR asserted mid-count SHALL abort any pending tc, with no glitch on Q beyond the transition to 0.

Structure
REQ-029 A shared package SHALL hold the SAT mode constants (SAT_WRAP=0, SAT_HOLD=1) and the default WIDTH constant.
REQ-030 Next-state logic SHALL be a single combinational block feeding one register stage.
REQ-031 The register stage SHALL be sub-module dffpc_n: WIDTH-bit D register with async active-low clear, instantiated once for Q and reused at width 1 for tc and sat_hit.

Verification (WIDTH=4)
REQ-032 SAT=0, lim=5, X=1, en=1 for 8 cycles after reset release -> Q 1,2,3,4,5,0,1,2; tc=1 only on the cycle Q becomes 0.
REQ-033 SAT=0, lim=5, X=0 from Q=0, en=1 for 3 cycles -> Q 5,4,3; tc=1 on the first cycle.
REQ-034 SAT=1, lim=9, load 8 then X=1 for 3 cycles -> Q 8,9,9,9; tc=1 on each hold cycle; sat_hit=1 from the first hold until sclr.
REQ-035 ld=1 with ld_val=12, lim=7 -> Q=7; same cycle with sclr=1 -> Q=0 (sclr wins).
REQ-036 Q=10, lim changed to 6, en=1, X=1 -> Q=0 with tc=1; repeat with X=0 -> Q=6 with tc=0.
REQ-037 CLR pulsed low 3 ns mid-cycle at Q=4 -> Q=0 before the next edge; counting resumes 1,2,… after release.
